mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store unit placed between the M-stage pipeline register and data memory. It generalises load extension to a configurable data-bus width (32 or 64 bits) and adds a request/acknowledge memory handshake with wait states. It also generates store byte-enables and lane data, detects misalignment and illegal ops, and aborts on a bus timeout. The pipeline stalls on `busy` while an access is outstanding.

## Interface
- DW, 32, data-bus width in bits; legal values 32 or 64
- AW, 32, byte-address width
- TIMEOUT, 15, maximum cycles `mem_req` stays high without `mem_ack` before abort; must be ≥1
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 8 SB, 9 SH, 10 SW, 11 SD; all other codes are illegal
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DW  extended load result; 0 for stores and exceptions
- resp_exc  out  2  00 ok, 01 misaligned, 10 illegal op, 11 timeout
- busy  out  1  high when state ≠ IDLE
- mem_req  out  1  memory access request, held until ack or timeout
- mem_we  out  1  write strobe qualifying `mem_req`
- mem_addr  out  AW  `req_addr` with low log2(DW/8) bits cleared
- mem_be  out  DW/8  byte enables
- mem_wdata  out  DW  store data shifted into its byte lanes
- mem_ack  in  1  memory completed the access (read data valid this cycle)
- mem_rdata  in  DW  read data, full aligned word

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS:
  - Condition: `req_valid` is high, the op is legal, and the address is aligned.
  - Actions: latch op, byte offset, `mem_addr`, `mem_be` and `mem_wdata`; set `mem_req` high.
- IDLE → RESP (no memory access is made):
  - Illegal op: `resp_exc=10`. LWU, LD and SD are illegal when DW=32.
  - Misaligned address: `resp_exc=01`. Half accesses require addr[0]=0, word accesses require addr[1:0]=0, doubleword accesses require addr[2:0]=0.
  - If an op is both illegal and misaligned, illegal takes priority.
- ACCESS → RESP on `mem_ack`:
  - Loads: select the addressed lane of `mem_rdata`, then sign-extend (LB, LH, LW) or zero-extend (LBU, LHU, LWU) to DW. LD passes the data through.
  - Stores: `resp_data=0`.
  - `mem_req` drops in the cycle after the ack.
- ACCESS → RESP on timeout:
  - The wait counter counts cycles with `mem_req` high and no ack.
  - When the counter reaches TIMEOUT, drop `mem_req` and set `resp_exc=11`, `resp_data=0`.
  - An ack in the same cycle as the timeout wins, and the access completes normally.
- RESP → IDLE unconditionally after one cycle.
- `req_ready` = (state==IDLE). Requests arriving while busy are not sampled.
- Byte enables:
  - SB: single bit at the offset.
  - SH: 2 bits.
  - SW: 4 bits.
  - SD: all 8 bits.
  - Loads: the same pattern as the matching store width, with `mem_we=0`.
- `mem_ack` in IDLE or RESP is ignored.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-ACCESS):
  - State=IDLE and the counter clears.
  - All outputs are 0 except `req_ready=1`.
  - An in-flight access is abandoned with no response.
- Request accepted at edge N → `mem_req`/`mem_addr`/`mem_be`/`mem_we`/`mem_wdata` registered high and valid from cycle N+1.
- `mem_ack` sampled high at edge K → `resp_valid` high during cycle K+1, `busy` low from K+2.
- Minimum latency (ack in the first request cycle): 2 cycles from accept to `resp_valid`.
- Exception path: accept at N → `resp_valid` during N+1, with `mem_req` never asserted.
- Timeout: `mem_req` high for exactly TIMEOUT cycles; `resp_valid` in the next cycle.
- `resp_data` and `resp_exc` are registered and valid only while `resp_valid=1`. They are 0 otherwise.
- Back-to-back: next accept earliest in the cycle after RESP (throughput of one access per 3+ cycles).

## Test plan
- LB then LBU, DW=32: addr 0x1003, mem_rdata 0x80FF7F01 with ack in the first cycle → `resp_data` 0xFFFFFF80 then 0x00000080, `mem_addr` 0x1000, `mem_be` 4'b1000.
- SH, DW=32: addr 0x2002, wdata 0x0000BEEF, ack after 3 wait cycles → `mem_we`=1, `mem_be` 4'b1100, `mem_wdata` 0xBEEF0000, `mem_req` high 4 cycles, `resp_valid` 1 cycle later, `resp_exc` 00.
- Misaligned LW at 0x3002 and illegal op 7 → each gives `resp_valid` in the next cycle with `resp_exc` 01 and 10 respectively, and `mem_req` never rises. LD at DW=32 → 10.
- DW=64 LWU at 0x4004, mem_rdata 0x89ABCDEF_01234567 → `resp_data` 0x00000000_89ABCDEF. LW at the same address → 0xFFFFFFFF_89ABCDEF.
- Timeout, TIMEOUT=4, no ack → `mem_req` high exactly 4 cycles, then `resp_exc` 11. Ack on the 4th cycle → normal completion.
- Assert `reset_n` low two cycles into ACCESS → `mem_req` and `busy` go low immediately, no `resp_valid`, and `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the M-stage register and data memory: decodes the op, drives a
// req/ack memory handshake with timeout, and returns extended load data or an exception code.
module mem_access_unit #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   output logic            resp_valid,
   output logic [DW-1:0]   resp_data,
   output logic [1:0]      resp_exc,
   output logic            busy,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW/8-1:0] mem_be,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int BW = DW / 8;
   localparam int OW = $clog2(BW);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;

   logic          op_legal;
   logic          op_sext;
   logic          op_store;
   logic          op_misal;
   logic [1:0]    op_size;
   logic [OW-1:0] req_off;
   logic [BW-1:0] be_base;

   logic [1:0]    size_p1;
   logic          sext_p1;
   logic          store_p1;
   logic [OW-1:0] off_p1;

   // Shift the addressed lane down, then sign- or zero-extend it to the bus width.
   function automatic logic [DW-1:0] ld_extend(input logic [DW-1:0] rdata,
                                               input logic [OW-1:0] off,
                                               input logic [1:0]    size,
                                               input logic          sext);
      logic [DW-1:0]      lane;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      lane = rdata >> {off, 3'b000};
      b    = signed'(lane[7:0]);
      h    = signed'(lane[15:0]);
      w    = signed'(lane[31:0]);
      case (size)
         2'd0:    ld_extend = sext ? DW'(b) : DW'(lane[7:0]);
         2'd1:    ld_extend = sext ? DW'(h) : DW'(lane[15:0]);
         2'd2:    ld_extend = sext ? DW'(w) : DW'(lane[31:0]);
         default: ld_extend = lane;
      endcase
   endfunction

   always_comb begin
      op_legal = 1'b1;
      op_sext  = 1'b0;
      op_size  = 2'd0;
      op_store = req_op[3];
      case (req_op)
         4'd0:    op_sext = 1'b1;
         4'd1:    op_size = 2'd0;
         4'd2:    begin op_size = 2'd1; op_sext = 1'b1; end
         4'd3:    op_size = 2'd1;
         4'd4:    begin op_size = 2'd2; op_sext = 1'b1; end
         4'd5:    begin op_size = 2'd2; op_legal = (DW == 64); end
         4'd6:    begin op_size = 2'd3; op_legal = (DW == 64); end
         4'd8:    op_size = 2'd0;
         4'd9:    op_size = 2'd1;
         4'd10:   op_size = 2'd2;
         4'd11:   begin op_size = 2'd3; op_legal = (DW == 64); end
         default: op_legal = 1'b0;
      endcase

      case (op_size)
         2'd0:    op_misal = 1'b0;
         2'd1:    op_misal = req_addr[0];
         2'd2:    op_misal = |req_addr[1:0];
         default: op_misal = |req_addr[2:0];
      endcase

      case (op_size)
         2'd0:    be_base = BW'(8'h01);
         2'd1:    be_base = BW'(8'h03);
         2'd2:    be_base = BW'(8'h0F);
         default: be_base = BW'(8'hFF);
      endcase
   end

   assign req_off   = req_addr[OW-1:0];
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // ACCESS-stage copies of the decoded request; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         size_p1  <= op_size;
         sext_p1  <= op_sext;
         store_p1 <= op_store;
         off_p1   <= req_off;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_exc   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               resp_data  <= '0;
               resp_exc   <= 2'b00;
               if (req_valid) begin
                  if (!op_legal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_exc   <= 2'b10;
                  end else if (op_misal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_exc   <= 2'b01;
                  end else begin
                     state     <= ACCESS;
                     wait_cnt  <= '0;
                     mem_req   <= 1'b1;
                     mem_we    <= op_store;
                     mem_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                     mem_be    <= be_base << req_off;
                     mem_wdata <= req_wdata << {req_off, 3'b000};
                  end
               end
            end
            ACCESS: begin
               // An ack arriving on the final wait cycle takes priority over the timeout.
               if (mem_ack) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_exc   <= 2'b00;
                  resp_data  <= store_p1 ? '0 : ld_extend(mem_rdata, off_p1, size_p1, sext_p1);
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_exc   <= 2'b11;
                  resp_data  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_data  <= '0;
               resp_exc   <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance share stimulus, a vector table
// drives accesses, and a scoreboard queue checks every response pulse.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        sel64;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   logic        ready32, rv32, busy32, mreq32, mwe32;
   logic [31:0] rd32, maddr32, mwd32;
   logic [1:0]  exc32;
   logic [3:0]  be32;

   logic        ready64, rv64, busy64, mreq64, mwe64;
   logic [63:0] rd64, mwd64;
   logic [31:0] maddr64;
   logic [1:0]  exc64;
   logic [7:0]  be64;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.DW(32), .AW(32), .TIMEOUT(4)) u32 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid & ~sel64), .req_ready(ready32), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .resp_valid(rv32), .resp_data(rd32), .resp_exc(exc32), .busy(busy32),
      .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32), .mem_be(be32),
      .mem_wdata(mwd32), .mem_ack(mem_ack & ~sel64), .mem_rdata(mem_rdata[31:0])
   );

   mem_access_unit #(.DW(64), .AW(32), .TIMEOUT(4)) u64 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid & sel64), .req_ready(ready64), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv64), .resp_data(rd64), .resp_exc(exc64), .busy(busy64),
      .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64), .mem_be(be64),
      .mem_wdata(mwd64), .mem_ack(mem_ack & sel64), .mem_rdata(mem_rdata)
   );

   logic        req_ready_s, resp_valid_s, busy_s, mem_req_s, mem_we_s;
   logic [63:0] resp_data_s, mem_wdata_s;
   logic [31:0] mem_addr_s;
   logic [7:0]  mem_be_s;
   logic [1:0]  resp_exc_s;

   assign req_ready_s  = sel64 ? ready64 : ready32;
   assign resp_valid_s = sel64 ? rv64    : rv32;
   assign busy_s       = sel64 ? busy64  : busy32;
   assign mem_req_s    = sel64 ? mreq64  : mreq32;
   assign mem_we_s     = sel64 ? mwe64   : mwe32;
   assign resp_data_s  = sel64 ? rd64    : {32'b0, rd32};
   assign mem_wdata_s  = sel64 ? mwd64   : {32'b0, mwd32};
   assign mem_addr_s   = sel64 ? maddr64 : maddr32;
   assign mem_be_s     = sel64 ? be64    : {4'b0, be32};
   assign resp_exc_s   = sel64 ? exc64   : exc32;

   typedef struct {
      logic        is64;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          ack_delay;
      logic [31:0] exp_addr;
      logic [7:0]  exp_be;
      logic        exp_we;
      logic [63:0] exp_wdata;
      logic [63:0] exp_data;
      logic [1:0]  exp_exc;
      int          exp_cycles;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  exc;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[19];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Response monitor: every resp_valid pulse pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         check("idle_dut_resp", {63'b0, sel64 ? rv32 : rv64}, 64'd0);
         if (resp_valid_s) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got data 0x%h exc %0d, expected no response",
                        resp_data_s, resp_exc_s);
            end else begin
               e = sb_q.pop_front();
               check("resp_data", resp_data_s, e.data);
               check("resp_exc", {62'b0, resp_exc_s}, {62'b0, e.exc});
            end
         end else begin
            check("resp_zero_when_idle", resp_data_s | {62'b0, resp_exc_s}, 64'd0);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int cyc;
      @(negedge clk);
      sel64     = v.is64;
      req_op    = v.op;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_valid = 1'b1;
      sb_q.push_back('{v.exp_data, v.exp_exc});
      #1;
      check("req_ready", {63'b0, req_ready_s}, 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      for (int c = 0; c < 40; c++) begin
         if (!mem_req_s) break;
         cyc++;
         if (c == 0) begin
            check("mem_addr", {32'b0, mem_addr_s}, {32'b0, v.exp_addr});
            check("mem_be", {56'b0, mem_be_s}, {56'b0, v.exp_be});
            check("mem_we", {63'b0, mem_we_s}, {63'b0, v.exp_we});
            check("mem_wdata", mem_wdata_s, v.exp_wdata);
         end
         if (c == v.ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
         end
         @(negedge clk);
         mem_ack = 1'b0;
      end
      check("mem_req_cycles", 64'(cyc), 64'(v.exp_cycles));
      @(negedge clk);
      check("busy_after_resp", {63'b0, busy_s}, 64'd0);
      check("ready_after_resp", {63'b0, req_ready_s}, 64'd1);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b1;
      sel64     = 1'b0;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_addr  = '0;
      req_wdata = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;

      //          is64  op     addr        wdata                   rdata                  dly  exp_addr    be     we    exp_wdata               exp_data                exc   cyc
      vecs[0]  = '{1'b0, 4'd0,  32'h1003, 64'h0,                  64'h80FF7F01,          0,   32'h1000, 8'h08, 1'b0, 64'h0,                  64'hFFFFFF80,          2'd0, 1};
      vecs[1]  = '{1'b0, 4'd1,  32'h1003, 64'h0,                  64'h80FF7F01,          0,   32'h1000, 8'h08, 1'b0, 64'h0,                  64'h00000080,          2'd0, 1};
      vecs[2]  = '{1'b0, 4'd3,  32'h1002, 64'h0,                  64'h80FF7F01,          2,   32'h1000, 8'h0C, 1'b0, 64'h0,                  64'h000080FF,          2'd0, 3};
      vecs[3]  = '{1'b0, 4'd9,  32'h2002, 64'h0000BEEF,           64'h0,                 3,   32'h2000, 8'h0C, 1'b1, 64'hBEEF0000,           64'h0,                 2'd0, 4};
      vecs[4]  = '{1'b0, 4'd4,  32'h3002, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd1, 0};
      vecs[5]  = '{1'b0, 4'd7,  32'h3000, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd2, 0};
      vecs[6]  = '{1'b0, 4'd6,  32'h3000, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd2, 0};
      vecs[7]  = '{1'b0, 4'd6,  32'h3001, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd2, 0};
      vecs[8]  = '{1'b0, 4'd4,  32'h5000, 64'h0,                  64'h0,                 255, 32'h5000, 8'h0F, 1'b0, 64'h0,                  64'h0,                 2'd3, 4};
      vecs[9]  = '{1'b0, 4'd10, 32'h5004, 64'h12345678,           64'h0,                 3,   32'h5004, 8'h0F, 1'b1, 64'h12345678,           64'h0,                 2'd0, 4};
      vecs[10] = '{1'b1, 4'd5,  32'h4004, 64'h0,                  64'h89ABCDEF01234567,  0,   32'h4000, 8'hF0, 1'b0, 64'h0,                  64'h0000000089ABCDEF,  2'd0, 1};
      vecs[11] = '{1'b1, 4'd4,  32'h4004, 64'h0,                  64'h89ABCDEF01234567,  0,   32'h4000, 8'hF0, 1'b0, 64'h0,                  64'hFFFFFFFF89ABCDEF,  2'd0, 1};
      vecs[12] = '{1'b1, 4'd8,  32'h6005, 64'hAB,                 64'h0,                 1,   32'h6000, 8'h20, 1'b1, 64'h0000AB0000000000,   64'h0,                 2'd0, 2};
      vecs[13] = '{1'b1, 4'd2,  32'h7006, 64'h0,                  64'h8001000000000000,  0,   32'h7000, 8'hC0, 1'b0, 64'h0,                  64'hFFFFFFFFFFFF8001,  2'd0, 1};
      vecs[14] = '{1'b1, 4'd11, 32'h7004, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd1, 0};
      vecs[15] = '{1'b1, 4'd11, 32'h7008, 64'h1122334455667788,   64'h0,                 2,   32'h7008, 8'hFF, 1'b1, 64'h1122334455667788,   64'h0,                 2'd0, 3};
      vecs[16] = '{1'b1, 4'd6,  32'h7010, 64'h0,                  64'hFEDCBA9876543210,  1,   32'h7010, 8'hFF, 1'b0, 64'h0,                  64'hFEDCBA9876543210,  2'd0, 2};
      vecs[17] = '{1'b1, 4'd12, 32'h7000, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd2, 0};
      vecs[18] = '{1'b0, 4'd5,  32'h0000, 64'h0,                  64'h0,                 0,   32'h0,    8'h00, 1'b0, 64'h0,                  64'h0,                 2'd2, 0};

      #2 reset_n = 1'b0;
      #1;
      check("rst32_ctl", {46'b0, mreq32, mwe32, rv32, busy32, exc32, be32, 8'b0}, 64'd0);
      check("rst32_data", {32'b0, maddr32 | mwd32 | rd32}, 64'd0);
      check("rst32_ready", {63'b0, ready32}, 64'd1);
      check("rst64_ctl", {50'b0, mreq64, mwe64, rv64, busy64, exc64, be64}, 64'd0);
      check("rst64_data", {32'b0, maddr64} | mwd64 | rd64, 64'd0);
      check("rst64_ready", {63'b0, ready64}, 64'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stray ack while idle must be ignored by both instances.
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = '1;
      repeat (2) begin
         @(negedge clk);
         check("idle_ack_busy", {62'b0, busy32, busy64}, 64'd0);
         check("idle_ack_req", {62'b0, mreq32, mreq64}, 64'd0);
      end
      mem_ack = 1'b0;

      // Asynchronous reset two cycles into an access abandons it with no response.
      @(negedge clk);
      sel64     = 1'b0;
      req_op    = 4'd4;
      req_addr  = 32'h8000;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_rst_req_before", {63'b0, mem_req_s}, 64'd1);
      @(negedge clk);
      check("mid_rst_busy_before", {63'b0, busy_s}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_req_now", {63'b0, mem_req_s}, 64'd0);
      check("mid_rst_busy_now", {63'b0, busy_s}, 64'd0);
      check("mid_rst_resp_now", {63'b0, resp_valid_s}, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("mid_rst_ready_after", {63'b0, req_ready_s}, 64'd1);
      repeat (3) begin
         @(negedge clk);
         check("post_rst_quiet", {62'b0, busy_s, mem_req_s}, 64'd0);
      end
      check("post_rst_no_pending", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
